// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline package for the unified-memory arbiter: FSM state type,
// memory request record and default bus widths.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_REQ   = 3'd1,
        IF_RESP  = 3'd2,
        IF_DRAIN = 3'd3,
        DM_REQ   = 3'd4,
        DM_RESP  = 3'd5
    } mem_arb_state_t;

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_W-1:0]     addr;
        logic [DEF_DATA_W-1:0]     wdata;
        logic [DEF_DATA_W/8-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and memory stage (MEM), MEM first.
// Optional MEM_ARB_PERF_EN adds the saturating perf_if_blocked counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]         perf_if_blocked,
`endif
    output logic                stall_if,
    output logic                stall_mem
);

    mem_arb_state_t    state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              mem_req_q, mem_req_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              idle_ready;

    // The requester still holds its request during its valid pulse, so IDLE
    // must not accept anything in that cycle or it would repeat the access.
    assign idle_ready = ~if_valid_q & ~dm_valid_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mem_req_d  = mem_req_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (idle_ready) begin
                    if (dm_req) begin
                        state_d     = DM_REQ;
                        mem_req_d   = 1'b1;
                        req_d.we    = dm_we;
                        req_d.addr  = dm_addr;
                        req_d.wdata = dm_wdata;
                        req_d.be    = dm_be;
                    end else if (if_req && !if_kill) begin
                        state_d     = IF_REQ;
                        mem_req_d   = 1'b1;
                        req_d.we    = 1'b0;
                        req_d.addr  = if_addr;
                        req_d.wdata = '0;
                        req_d.be    = '1;
                    end
                end
            end
            IF_REQ: begin
                if (if_kill) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_gnt ? IF_DRAIN : IDLE;
                end else if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = IF_RESP;
                end
            end
            IF_RESP: begin
                // A kill coinciding with the response consumes it here.
                if (if_kill) begin
                    state_d = mem_rvalid ? IDLE : IF_DRAIN;
                end else if (mem_rvalid) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            IF_DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            DM_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = DM_RESP;
                end
            end
            DM_RESP: begin
                if (mem_rvalid) begin
                    state_d    = IDLE;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            mem_req_q  <= mem_req_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_be    = req_q.be;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_q;
    logic        if_blocked;

    // Fetch waiting only because the data side owns or is claiming the port.
    assign if_blocked = if_req && !if_valid_q &&
                        (state_q == DM_REQ || state_q == DM_RESP ||
                         (state_q == IDLE && dm_req));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (if_blocked && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_if_blocked = perf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios, then randomized traffic
// against a transaction-level memory/requester model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_if, stall_mem;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_blocked;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_if_blocked(perf_if_blocked),
`endif
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 0; if_addr = 0; if_kill = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Word-addressed backing store; unwritten words read a hash of the address.
    logic [31:0] mem_aa [int];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_aa.exists(int'(a[31:2]))) return mem_aa[int'(a[31:2])];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_aa[int'(a[31:2])] = w;
    endfunction

    // Random-phase model state
    bit          outst, resp_fetch, fetch_live, exp_ifv, exp_dmv, if_next, dm_next, pend_chk;
    int          resp_cnt, if_wait, dm_wait, n_ifdone, n_dmdone;
    logic [31:0] resp_data, exp_if_d, exp_dm_d, pend_addr, pend_wdata;
    logic        pend_we;
    logic [3:0]  pend_be;

    initial begin
        drive_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);   check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);     check("rst_if_valid", if_valid, 0);
        check("rst_if_rdata", if_rdata, 0); check("rst_dm_valid", dm_valid, 0);
        check("rst_dm_rdata", dm_rdata, 0);
`ifdef MEM_ARB_PERF_EN
        check("rst_perf", perf_if_blocked, 0);
`endif
        reset = 1'b1;

        // Lone fetch: request in cycle 0, valid in cycle 3
        if_req = 1; if_addr = 32'h100; #1;
        check("lf_stall_c0", stall_if, 1);
        tick();
        check("lf_mreq_c1", mem_req, 1); check("lf_maddr_c1", mem_addr, 32'h100);
        check("lf_mwe_c1", mem_we, 0);   check("lf_mbe_c1", mem_be, 4'hF);
        check("lf_stall_c1", stall_if, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        check("lf_mreq_c2", mem_req, 0); check("lf_stall_c2", stall_if, 1);
        tick();
        mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
        check("lf_ifv_c3", if_valid, 1); check("lf_ifd_c3", if_rdata, 32'h0050_0093);
        check("lf_stall_c3", stall_if, 0);
        tick();
        if_req = 0;
        check("lf_ifv_c4", if_valid, 0); check("lf_mreq_c4", mem_req, 0);

        // Simultaneous fetch and load: data first
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_wdata = 0; dm_be = 4'hF; #1;
        check("sim_stall_mem_c0", stall_mem, 1);
        tick();
        check("sim_mreq_c1", mem_req, 1); check("sim_maddr_c1", mem_addr, 32'h2000);
        check("sim_mwe_c1", mem_we, 0);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 0;
        check("sim_dmv_c3", dm_valid, 1); check("sim_dmd_c3", dm_rdata, 32'h1111_2222);
        check("sim_ifv_c3", if_valid, 0); check("sim_stall_mem_c3", stall_mem, 0);
        check("sim_stall_if_c3", stall_if, 1);
        tick();
        dm_req = 0;
        check("sim_mreq_c4", mem_req, 0); check("sim_dmv_c4", dm_valid, 0);
        tick();
        check("sim_mreq_c5", mem_req, 1); check("sim_maddr_c5", mem_addr, 32'h104);
`ifdef MEM_ARB_PERF_EN
        check("sim_perf_blocked", perf_if_blocked, 4);
`endif
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h3333_4444;
        tick();
        mem_rvalid = 0;
        check("sim_ifv_c7", if_valid, 1); check("sim_ifd_c7", if_rdata, 32'h3333_4444);
        tick();
        if_req = 0;

        // Store with grant withheld for 5 cycles
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("st_mreq", mem_req, 1);          check("st_maddr", mem_addr, 32'h2004);
            check("st_mwdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_mwe", mem_we, 1);            check("st_mbe", mem_be, 4'b0011);
            check("st_dmv_wait", dm_valid, 0);
        end
        tick();
        check("st_mreq_c6", mem_req, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1;
        check("st_mreq_c7", mem_req, 0); check("st_dmv_c7", dm_valid, 0);
        tick();
        mem_rvalid = 0;
        check("st_dmv_c8", dm_valid, 1);
        tick();
        dm_req = 0; dm_we = 0;
        check("st_dmv_c9", dm_valid, 0);

        // Kill while waiting for the response
        if_req = 1; if_addr = 32'h108;
        tick();
        check("kr_mreq_c1", mem_req, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; if_kill = 1;
        tick();
        if_kill = 0; if_addr = 32'h200; #1;
        check("kr_ifv_c3", if_valid, 0); check("kr_mreq_c3", mem_req, 0);
        check("kr_stall_c3", stall_if, 1);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        check("kr_ifv_c4", if_valid, 0);
        tick();
        mem_rvalid = 0;
        check("kr_ifv_c5", if_valid, 0); check("kr_mreq_c5", mem_req, 0);
        tick();
        check("kr_mreq_c6", mem_req, 1); check("kr_maddr_c6", mem_addr, 32'h200);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00C0_0113;
        tick();
        mem_rvalid = 0;
        check("kr_ifv_c8", if_valid, 1); check("kr_ifd_c8", if_rdata, 32'h00C0_0113);
        tick();
        if_req = 0;

        // Kill before grant withdraws the request
        if_req = 1; if_addr = 32'h10C;
        tick();
        check("kq_mreq_c1", mem_req, 1);
        if_kill = 1;
        tick();
        if_kill = 0; if_addr = 32'h110;
        check("kq_mreq_c2", mem_req, 0);
        tick();
        check("kq_mreq_c3", mem_req, 1); check("kq_maddr_c3", mem_addr, 32'h110);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 0;
        check("kq_ifv_c5", if_valid, 1); check("kq_ifd_c5", if_rdata, 32'h1234_5678);
        tick();
        if_req = 0;

        // Asynchronous reset in DM_RESP, then a fresh fetch
        dm_req = 1; dm_we = 0; dm_addr = 32'h2008; dm_wdata = 32'h55AA_55AA; dm_be = 4'hF;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        reset = 1'b0; #1;
        check("ar_mreq", mem_req, 0);     check("ar_maddr", mem_addr, 0);
        check("ar_mwdata", mem_wdata, 0); check("ar_mbe", mem_be, 0);
        check("ar_dmv", dm_valid, 0);     check("ar_ifd", if_rdata, 0);
        drive_idle();
        tick();
        reset = 1'b1;
        if_req = 1; if_addr = 32'h300;
        tick();
        check("ar_mreq_c1", mem_req, 1); check("ar_maddr_c1", mem_addr, 32'h300);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0AB0_0AB0;
        tick();
        mem_rvalid = 0;
        check("ar_ifv_c3", if_valid, 1); check("ar_ifd_c3", if_rdata, 32'h0AB0_0AB0);
        tick();
        drive_idle();

        // Randomized traffic
        outst = 0; fetch_live = 0; exp_ifv = 0; exp_dmv = 0; if_next = 0; dm_next = 0;
        pend_chk = 0; if_wait = 0; dm_wait = 0; n_ifdone = 0; n_dmdone = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            check("rnd_if_valid", if_valid, exp_ifv);
            if (exp_ifv) check("rnd_if_rdata", if_rdata, exp_if_d);
            check("rnd_dm_valid", dm_valid, exp_dmv);
            if (exp_dmv && !dm_we) check("rnd_dm_rdata", dm_rdata, exp_dm_d);
            if (pend_chk) begin
                check("rnd_hold_req", mem_req, 1);   check("rnd_hold_addr", mem_addr, pend_addr);
                check("rnd_hold_we", mem_we, pend_we); check("rnd_hold_be", mem_be, pend_be);
                if (pend_we) check("rnd_hold_wdata", mem_wdata, pend_wdata);
            end

            if (if_next) begin
                if_next = 0;
                if_req = 1'($urandom_range(0, 1));
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1;
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if_kill = 0;
            if (if_valid) begin
                if_next = 1; n_ifdone++;
            end else if (if_req && $urandom_range(0, 7) == 0) begin
                if_kill = 1; if_next = 1;
            end

            if (dm_next || (!dm_req && $urandom_range(0, 3) == 0)) begin
                dm_next = 0;
                dm_req = (dm_req) ? 1'($urandom_range(0, 1)) : 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
                dm_wdata = $urandom;
                dm_be = dm_we ? 4'($urandom_range(1, 15)) : 4'hF;
            end
            if (dm_valid) begin
                dm_next = 1; n_dmdone++;
            end

            mem_rvalid = 0; mem_rdata = $urandom; exp_ifv = 0; exp_dmv = 0;
            if (outst) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_rvalid = 1; mem_rdata = resp_data; outst = 0;
                    if (resp_fetch) begin
                        exp_ifv = fetch_live && !if_kill; exp_if_d = resp_data;
                    end else begin
                        exp_dmv = 1; exp_dm_d = resp_data;
                    end
                end
            end

            mem_gnt = 0; pend_chk = 0;
            if (mem_req && !outst && !mem_rvalid) begin
                if ($urandom_range(0, 2) != 0) begin
                    mem_gnt = 1; outst = 1; resp_cnt = $urandom_range(1, 3);
                    if (mem_addr >= 32'h2000) begin
                        resp_fetch = 0;
                        check("rnd_gnt_dm_req", dm_req, 1); check("rnd_gnt_dm_addr", mem_addr, dm_addr);
                        check("rnd_gnt_dm_we", mem_we, dm_we); check("rnd_gnt_dm_be", mem_be, dm_be);
                        if (dm_we) begin
                            check("rnd_gnt_dm_wdata", mem_wdata, dm_wdata);
                            mem_wr(dm_addr, dm_wdata, dm_be);
                            resp_data = $urandom;
                        end else begin
                            resp_data = mem_rd(dm_addr);
                        end
                    end else begin
                        resp_fetch = 1; fetch_live = 1;
                        check("rnd_gnt_if_req", if_req, 1); check("rnd_gnt_if_addr", mem_addr, if_addr);
                        check("rnd_gnt_if_we", mem_we, 0);  check("rnd_gnt_if_be", mem_be, 4'hF);
                        resp_data = mem_rd(if_addr);
                    end
                end else if (!(if_kill && mem_addr < 32'h2000)) begin
                    pend_chk = 1; pend_addr = mem_addr; pend_we = mem_we;
                    pend_be = mem_be; pend_wdata = mem_wdata;
                end
            end
            if (if_kill) fetch_live = 0;

            #1;
            check("rnd_stall_if", stall_if, if_req & ~if_valid);
            check("rnd_stall_mem", stall_mem, dm_req & ~dm_valid);

            if (if_req && !if_valid && !if_kill) if_wait++; else if_wait = 0;
            if (dm_req && !dm_valid) dm_wait++; else dm_wait = 0;
            if (if_wait > 100) begin
                check("rnd_if_timeout", 32'(if_wait), 0); if_wait = 0;
            end
            if (dm_wait > 100) begin
                check("rnd_dm_timeout", 32'(dm_wait), 0); dm_wait = 0;
            end
        end
        check("rnd_if_progress", 32'(n_ifdone > 50), 1);
        check("rnd_dm_progress", 32'(n_dmdone > 20), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the five-stage pipeline: shares one unified instruction/data memory port between the fetch stage (IF) and the memory stage (MEM). It sequences one outstanding memory transaction at a time, gives MEM priority over IF, and produces stall requests for the hazard unit. It also discards fetch responses made stale by a taken branch or jump.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  ADDR_W  fetch address (PCF)
- if_kill  in  1  redirect (PCSrcE); cancels any in-flight fetch
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request; held with all dm_* inputs until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address (ALUResultM)
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_valid  out  1  one-cycle pulse; load data returned or store acknowledged
- dm_rdata  out  DATA_W  load data
- mem_req, mem_we, mem_addr, mem_wdata, mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request, registered
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  response/ack; never in the same cycle as the matching mem_gnt
- mem_rdata  in  DATA_W  response data
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  dm_req & ~dm_valid

## Operation
- FSM states: IDLE, IF_REQ, IF_RESP, IF_DRAIN, DM_REQ, DM_RESP.
- IDLE transitions:
  - dm_req → DM_REQ; dm_* inputs are latched into the mem_* registers.
  - Otherwise, if_req & ~if_kill → IF_REQ; if_addr is latched, mem_we = 0, mem_be = all ones.
  - dm_req wins over if_req when both are asserted.
- X_REQ: mem_req = 1 and held stable. On mem_gnt, mem_req drops and the FSM goes to X_RESP.
- X_RESP: on mem_rvalid, X_valid = 1 next cycle and X_rdata = mem_rdata (registered); FSM returns to IDLE.
- Stores: dm_valid pulses on the ack. dm_rdata is don't-care.
- if_kill while in IF_REQ and mem_gnt = 0: withdraw mem_req and go to IDLE. No if_valid.
- if_kill while in IF_REQ with mem_gnt = 1, or while in IF_RESP: go to IF_DRAIN. Wait for mem_rvalid, then go to IDLE. No if_valid.
- if_kill has no effect in DM_* states or in IDLE.
- mem_rvalid in IDLE or X_REQ is ignored.
- stall_if and stall_mem are combinational, so the hazard unit can assert StallF/StallD in the same cycle.

## Timing
- Reset (async assert): state = IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid, if_rdata, dm_valid, dm_rdata, and the perf counter.
- Reset mid-transaction aborts the transaction. Memory shares the reset, so no stale response is expected.
- Minimum latency, request seen at edge 0:
  - edge 1: mem_req = 1, and mem_gnt = 1 in that cycle;
  - edge 2: mem_rvalid = 1;
  - edge 3: X_valid = 1.
  - Total: 3 cycles.
- A new request is evaluated in IDLE on the cycle after X_valid. Back-to-back throughput is one transaction per 4 cycles minimum.
- A dm_req arriving while a fetch is in flight waits for that fetch to complete. It is not preempted.

## Configuration
- MEM_ARB_PERF_EN defined: adds output perf_if_blocked [31:0]. It increments by 1 each cycle in which if_req = 1, if_valid = 0 and the FSM is in a DM_* state, or in IDLE with dm_req = 1. It saturates at 0xFFFFFFFF.
- MEM_ARB_PERF_EN undefined: the port and counter are absent. Arbitration behaviour is identical.

## Structure
- Shared package (pipeline package) holds:
  - the state enum `mem_arb_state_t`;
  - a request struct `mem_req_t` {we, addr, wdata, be};
  - ADDR_W/DATA_W defaults.
- Single module, no sub-modules. The optional perf counter is inline under the macro.

## Test plan
- Lone fetch: if_req = 1, if_addr = 0x100; memory grants immediately and returns 0x00500093 one cycle later → mem_addr = 0x100 at cycle 1, if_valid with if_rdata = 0x00500093 at cycle 3, stall_if high for cycles 0–2.
- Simultaneous requests: if_req = 1 (0x104) and dm_req = 1 load (0x2000) in the same cycle → data transaction first, dm_valid at cycle 3; fetch issues at cycle 5, if_valid at cycle 7.
- Store: dm_we = 1, dm_addr = 0x2004, dm_wdata = 0xDEADBEEF, dm_be = 0b0011 → mem_* carry exactly these values while mem_req = 1; dm_valid pulses after the ack.
- Kill during response: fetch granted, if_kill = 1 in IF_RESP, mem_rvalid two cycles later → IF_DRAIN entered, no if_valid, IDLE the cycle after mem_rvalid.
- Delayed grant: mem_gnt held low for 5 cycles → mem_req and mem_addr remain stable throughout; no dm_valid until grant + rvalid.
- Async reset asserted mid DM_RESP → all outputs 0 immediately; after release, a fresh fetch completes normally. With MEM_ARB_PERF_EN, perf_if_blocked counts the exact number of blocked cycles in the simultaneous-requests scenario.
